// File: rtl/uart_axil_pkg.sv
// Shared constants for the UART AXI4-Lite register block.
// Covers the word map, the FSM state encodings and the response code.
package uart_axil_pkg;
   localparam logic [1:0] CTRL      = 2'd0;
   localparam logic [1:0] BAUD      = 2'd1;
   localparam logic [1:0] TXDATA    = 2'd2;
   localparam logic [1:0] STATUS    = 2'd3;
   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_ADDR_OK, W_DATA_OK, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/uart_strb_merge.sv
// Byte-lane merge: lane b of the result comes from i_new when i_strb[b] is set,
// otherwise from i_old.
module uart_strb_merge #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   i_old,
   input  logic [DW-1:0]   i_new,
   input  logic [DW/8-1:0] i_strb,
   output logic [DW-1:0]   o_merged
);
   for (genvar b = 0; b < DW/8; b++) begin : g_lane
      assign o_merged[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
   end
endmodule

// File: rtl/uart_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers feeding the UART core.
// It pulses tx_wr_pulse whenever the TX data word is written.
module uart_axil_regs
   import uart_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
   output logic                            tx_wr_pulse
);
   localparam int DW = C_S_AXI_DATA_WIDTH;

   logic [DW-1:0]   r_regs [4];
   logic [DW-1:0]   r_rdata;
   logic [DW-1:0]   r_wdata;
   logic [DW/8-1:0] r_wstrb;
   logic [1:0]      r_awidx;
   logic            r_rst_hold;
   logic            r_tx_pulse;
   w_state_t        r_wstate, w_wstate_nxt;
   r_state_t        r_rstate, w_rstate_nxt;

   logic            w_aw_hs, w_w_hs, w_ar_hs, w_do_write;
   logic [1:0]      w_widx;
   logic [DW-1:0]   w_wdata, w_merged;
   logic [DW/8-1:0] w_wstrb;
   logic            w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Readies stay low for one cycle after reset so nothing is accepted while leaving it
   assign S_AXI_AWREADY = ~r_rst_hold & (r_wstate == W_IDLE || r_wstate == W_DATA_OK);
   assign S_AXI_WREADY  = ~r_rst_hold & (r_wstate == W_IDLE || r_wstate == W_ADDR_OK);
   assign S_AXI_ARREADY = ~r_rst_hold & (r_rstate == R_IDLE);
   assign S_AXI_BVALID  = (r_wstate == W_RESP);
   assign S_AXI_RVALID  = (r_rstate == R_DATA);
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign S_AXI_RDATA   = r_rdata;
   assign tx_wr_pulse   = r_tx_pulse;
   assign slv_reg0      = r_regs[CTRL];
   assign slv_reg1      = r_regs[BAUD];
   assign slv_reg2      = r_regs[TXDATA];
   assign slv_reg3      = r_regs[STATUS];

   assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // Whichever half arrives last is taken straight off the bus
   assign w_widx  = (r_wstate == W_ADDR_OK) ? r_awidx : S_AXI_AWADDR[3:2];
   assign w_wdata = (r_wstate == W_DATA_OK) ? r_wdata : S_AXI_WDATA;
   assign w_wstrb = (r_wstate == W_DATA_OK) ? r_wstrb : S_AXI_WSTRB;

   uart_strb_merge #(.DW(DW)) u_merge (
      .i_old    (r_regs[w_widx]),
      .i_new    (w_wdata),
      .i_strb   (w_wstrb),
      .o_merged (w_merged)
   );

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_do_write   = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_wstate_nxt = W_RESP;
               w_do_write   = 1'b1;
            end else if (w_aw_hs) begin
               w_wstate_nxt = W_ADDR_OK;
            end else if (w_w_hs) begin
               w_wstate_nxt = W_DATA_OK;
            end
         end
         W_ADDR_OK: if (w_w_hs) begin
            w_wstate_nxt = W_RESP;
            w_do_write   = 1'b1;
         end
         W_DATA_OK: if (w_aw_hs) begin
            w_wstate_nxt = W_RESP;
            w_do_write   = 1'b1;
         end
         W_RESP: if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_rst_hold <= 1'b1;
         r_wstate   <= W_IDLE;
         r_rstate   <= R_IDLE;
         r_rdata    <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_awidx    <= '0;
         r_tx_pulse <= 1'b0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else begin
         r_rst_hold <= 1'b0;
         r_wstate   <= w_wstate_nxt;
         r_rstate   <= w_rstate_nxt;
         r_tx_pulse <= w_do_write && (w_widx == TXDATA);
         if (w_aw_hs) r_awidx <= S_AXI_AWADDR[3:2];
         if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
         if (w_do_write) r_regs[w_widx] <= w_merged;
         // Sampled before this edge's write lands, so a same-cycle read sees the old value
         if (w_ar_hs) r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
      end
   end
endmodule

// File: tb/tb_uart_axil_regs.sv
// Directed plus randomized bench for uart_axil_regs.
// Expected register contents come from a word-array model updated by byte strobes.
module tb_uart_axil_regs;
   logic        S_AXI_ACLK = 1'b0;
   logic        S_AXI_ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
   logic        tx_wr_pulse;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] model [4];

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   uart_axil_regs dut (
      .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
      .tx_wr_pulse(tx_wr_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slv(input int idx);
      case (idx)
         0:       return slv_reg0;
         1:       return slv_reg1;
         2:       return slv_reg2;
         default: return slv_reg3;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      int idx, cyc;
      bit aw_done, w_done, aw_hs, w_hs;
      idx = int'(addr[3:2]);
      cyc = 0; aw_done = 0; w_done = 0;
      S_AXI_AWADDR = addr;
      S_AXI_AWPROT = 3'($urandom_range(7, 0));
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      while (!(aw_done && w_done)) begin
         if (cyc > 40) begin
            chk("wr_timeout", 32'd1, 32'd0);
            S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
            return;
         end
         S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         chk("bvalid_early", S_AXI_BVALID, 0);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
      end
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      model[idx] = merge(model[idx], data, strb);
      chk("bvalid", S_AXI_BVALID, 1);
      chk("bresp", S_AXI_BRESP, 0);
      chk("reg_update", slv(idx), model[idx]);
      chk("tx_pulse", tx_wr_pulse, (idx == 2) ? 1 : 0);
      S_AXI_BREADY = 0;
      for (int i = 0; i < b_dly; i++) begin
         tick();
         chk("bvalid_hold", S_AXI_BVALID, 1);
         chk("awready_hold", S_AXI_AWREADY, 0);
         chk("wready_hold", S_AXI_WREADY, 0);
         chk("tx_pulse_once", tx_wr_pulse, 0);
      end
      S_AXI_BREADY = 1;
      tick();
      S_AXI_BREADY = 0;
      chk("bvalid_clr", S_AXI_BVALID, 0);
      chk("tx_pulse_end", tx_wr_pulse, 0);
      chk("awready_idle", S_AXI_AWREADY, 1);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_dly);
      int idx, cyc;
      idx = int'(addr[3:2]);
      cyc = 0;
      S_AXI_ARADDR  = addr;
      S_AXI_ARPROT  = 3'($urandom_range(7, 0));
      S_AXI_ARVALID = 1;
      while (!S_AXI_ARREADY && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!S_AXI_ARREADY) begin
         chk("rd_timeout", 32'd1, 32'd0);
         S_AXI_ARVALID = 0;
         return;
      end
      tick();
      S_AXI_ARVALID = 0;
      chk("rvalid", S_AXI_RVALID, 1);
      chk("rdata", S_AXI_RDATA, model[idx]);
      chk("rresp", S_AXI_RRESP, 0);
      chk("arready_busy", S_AXI_ARREADY, 0);
      S_AXI_RREADY = 0;
      for (int i = 0; i < r_dly; i++) begin
         tick();
         chk("rvalid_hold", S_AXI_RVALID, 1);
         chk("rdata_hold", S_AXI_RDATA, model[idx]);
         chk("arready_hold", S_AXI_ARREADY, 0);
      end
      S_AXI_RREADY = 1;
      tick();
      S_AXI_RREADY = 0;
      chk("rvalid_clr", S_AXI_RVALID, 0);
      chk("arready_idle", S_AXI_ARREADY, 1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_awready"}, S_AXI_AWREADY, 0);
      chk({tag, "_wready"}, S_AXI_WREADY, 0);
      chk({tag, "_arready"}, S_AXI_ARREADY, 0);
      chk({tag, "_bvalid"}, S_AXI_BVALID, 0);
      chk({tag, "_rvalid"}, S_AXI_RVALID, 0);
      chk({tag, "_rdata"}, S_AXI_RDATA, 0);
      chk({tag, "_resp"}, {S_AXI_BRESP, S_AXI_RRESP}, 0);
      chk({tag, "_regs"}, slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 0);
      chk({tag, "_tx"}, tx_wr_pulse, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old, nv;
      S_AXI_ARESET = 1;
      S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
      S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
      S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
      for (int i = 0; i < 4; i++) model[i] = 0;
      repeat (3) tick();
      chk_reset_state("rst");
      S_AXI_ARESET = 0;
      chk("rst_rel_awready", S_AXI_AWREADY, 0);
      tick();
      chk("post_rst_awready", S_AXI_AWREADY, 1);
      chk("post_rst_wready", S_AXI_WREADY, 1);
      chk("post_rst_arready", S_AXI_ARREADY, 1);

      // basic write/read of all four words
      axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0);
      axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0, 0);
      axi_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0, 0);
      axi_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0, 0);
      chk("word0_const", slv_reg0, 32'h0101FFFF);
      chk("word3_const", slv_reg3, 32'hBEEF0011);
      for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

      // W before AW, then AW before W
      axi_write(4'h4, 32'h11112222, 4'hF, 3, 0, 0);
      axi_write(4'h4, 32'h33334444, 4'hF, 0, 3, 0);
      axi_read(4'h4, 0);

      // partial strobes
      axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axi_write(4'h5, 32'h12345678, 4'b0101, 0, 0, 0);
      chk("strb_merge_const", slv_reg1, 32'hFF34FF78);
      axi_read(4'h7, 0);

      // back-pressure on both response channels
      axi_write(4'h0, 32'hCAFEF00D, 4'hF, 1, 2, 5);
      axi_read(4'h0, 5);

      // tx pulse: word 2 pulses (also with strb 0), word 0 does not
      axi_write(4'h8, 32'h000000A5, 4'hF, 0, 0, 0);
      axi_write(4'h0, 32'h00000001, 4'hF, 0, 0, 0);
      axi_write(4'hA, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      chk("strb0_unchanged", slv_reg2, 32'h000000A5);

      // concurrent read and write of the same word
      old = model[3];
      nv  = $urandom;
      S_AXI_AWADDR = 4'hC; S_AXI_WDATA = nv; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'hC;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
      tick();
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      model[3] = nv;
      chk("same_cyc_rdata_old", S_AXI_RDATA, old);
      chk("same_cyc_reg_new", slv_reg3, nv);
      chk("same_cyc_bvalid", S_AXI_BVALID, 1);
      S_AXI_BREADY = 1; S_AXI_RREADY = 1;
      tick();
      S_AXI_BREADY = 0; S_AXI_RREADY = 0;
      chk("same_cyc_idle", {S_AXI_BVALID, S_AXI_RVALID}, 0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(1, 0) == 1)
            axi_write(4'($urandom_range(15, 0)), $urandom, 4'($urandom_range(15, 0)),
                      $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0));
         else
            axi_read(4'($urandom_range(15, 0)), $urandom_range(2, 0));
      end

      // reset between AW and W handshakes
      S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
      tick();
      S_AXI_AWVALID = 0;
      S_AXI_ARESET = 1;
      S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      tick();
      chk_reset_state("midrst");
      tick();
      S_AXI_ARESET = 0; S_AXI_WVALID = 0;
      for (int i = 0; i < 4; i++) model[i] = 0;
      chk("midrst_rel_awready", S_AXI_AWREADY, 0);
      tick();
      chk("midrst_awready", S_AXI_AWREADY, 1);
      chk("midrst_no_bvalid", S_AXI_BVALID, 0);
      chk("midrst_regs", slv_reg2, 0);
      axi_write(4'h8, 32'h0F0F1234, 4'hF, 0, 1, 1);
      axi_read(4'h8, 1);
      axi_read(4'h4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_axil_regs.md
UART_AXIL_REGS -- requirements
Module: uart_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 words).
REQ-003 SHALL have port S_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 SHALL have ports slv_reg0..slv_reg3 out 32 each: current register contents to the UART core.
REQ-011 SHALL have port tx_wr_pulse out 1: one-cycle strobe after any accepted write to word 2 (TX data).

Function
REQ-012 SHALL decode word index = AWADDR/ARADDR[3:2]; bits [1:0] ignored; AWPROT/ARPROT ignored.
REQ-013 SHALL hold four fully read/write 32-bit registers; write-then-read of any value at any word returns that value.
REQ-014 SHALL update byte lane n only when WSTRB[n]=1; WSTRB=0 leaves register unchanged but still yields a response.
REQ-015 Write FSM states: W_IDLE, W_ADDR_OK, W_DATA_OK, W_RESP; AW and W accepted independently in any order or same cycle.
REQ-016 AWREADY SHALL be high in W_IDLE and W_DATA_OK; WREADY high in W_IDLE and W_ADDR_OK; each captured on VALID&READY.
REQ-017 Register update SHALL occur on the cycle after both AW and W are captured; BVALID asserts in that same cycle (latency 1 from last handshake).
REQ-018 BVALID SHALL stay high, with AWREADY=WREADY=0, until BREADY; return to W_IDLE on BVALID&BREADY.
REQ-019 Read FSM states: R_IDLE, R_DATA; ARREADY high only in R_IDLE; RDATA registered from target word and RVALID high the cycle after AR handshake.
REQ-020 RDATA/RVALID SHALL stay stable until RREADY; ARREADY low meanwhile; back-to-back read costs 1 idle cycle minimum.
REQ-021 BRESP and RRESP SHALL always be 2'b00 (OKAY); no SLVERR/DECERR generated.
REQ-022 Read and write paths SHALL operate concurrently; read of a word written in the same cycle returns the pre-write value.
REQ-023 tx_wr_pulse SHALL be high exactly the cycle the word-2 register updates, even when WSTRB=0.

Reset
REQ-024 While S_AXI_ARESET=1 at a clock edge: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, slv_reg0..3 0, tx_wr_pulse 0, both FSMs to idle.
REQ-025 Reset mid-transaction SHALL abandon it without register update or response; first READY asserts the cycle after reset deasserts.

Structure
REQ-026 Word indices (CTRL=0, BAUD=1, TXDATA=2, STATUS=3), FSM state encodings and OKAY response constant SHALL live in shared package uart_axil_pkg.
REQ-027 SHALL be one module; byte-lane merge MAY be sub-module uart_strb_merge (old, new, strb -> merged).

Verification
REQ-028 Write 0x0101FFFF,0xABCD0001,0xDEAD0011,0xBEEF0011 to 0x0,0x4,0x8,0xC, read each back -> identical data, all responses OKAY.
REQ-029 W presented 3 cycles before AW, then AW before W by 3 cycles -> single update each, BVALID one cycle after last handshake.
REQ-030 reg1=0xFFFFFFFF then write 0x12345678 WSTRB=0101 -> readback 0xFF34FF78.
REQ-031 BREADY held low 5 cycles -> BVALID held, AWREADY/WREADY 0; RREADY low 5 cycles -> RDATA stable.
REQ-032 Write to 0x8 -> tx_wr_pulse high exactly 1 cycle; write to 0x0 -> no pulse.
REQ-033 Reset asserted between AW and W handshakes -> all registers 0, no BVALID, next full write completes normally.
